// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package arm_fetch_pkg;

  // Bytes per fetched instruction word; PC advances by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Fetch controller states.
  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,  // one idle cycle after reset
    S_REQ     = 2'd1,  // request outstanding or issuable
    S_DISCARD = 2'd2   // redirected mid-request; owed response is dropped
  } fetch_state_e;

endpackage

// File: rtl/arm_fetch_buffer.sv
// One-entry fetch output buffer (valid / instruction / pc / pc+4).
// Ports:
//   i_CLK, i_NRESET     clock, async active-low reset
//   load                capture instr_in/pc_in and mark valid
//   consume             downstream took the entry (clears valid unless load)
//   flush               redirect: clears valid, highest priority
//   instr_in, pc_in     entry payload
//   valid, instr, pc, pcplus4   registered buffer contents
module arm_fetch_buffer
  import arm_fetch_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned InstrWidth = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_NRESET,
  input  logic                  load,
  input  logic                  consume,
  input  logic                  flush,
  input  logic [InstrWidth-1:0] instr_in,
  input  logic [AddrWidth-1:0]  pc_in,
  output logic                  valid,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  pc,
  output logic [AddrWidth-1:0]  pcplus4
);

  // Buffer register; flush beats load beats consume for the valid bit.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      valid   <= 1'b0;
      instr   <= '0;
      pc      <= '0;
      pcplus4 <= AddrWidth'(INSTR_BYTES);
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end
      if (load && !flush) begin
        instr   <= instr_in;
        pc      <= pc_in;
        pcplus4 <= pc_in + AddrWidth'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: rtl/arm_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM and
// a one-entry output buffer feeding IF/ID.
// Ports:
//   i_CLK, i_NRESET                 clock, async active-low reset
//   o_IMEM_REQ, o_IMEM_ADDR         fetch request (held until i_IMEM_VALID)
//   i_IMEM_VALID, i_IMEM_RDATA      fetch response
//   i_STALL_F                       IF/ID not accepting this cycle
//   i_BRANCH_TAKEN, i_BRANCH_TARGET redirect from execute
//   o_VALID_F, o_INSTR_F, o_PC_F, o_PCPLUS4_F   buffered instruction
module arm_fetch_stage
  import arm_fetch_pkg::*;
#(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          InstrWidth  = 32,
  parameter logic [AddrWidth-1:0] ResetVector = AddrWidth'(RESET_VECTOR_DEF)
) (
  input  logic                  i_CLK,
  input  logic                  i_NRESET,
  output logic                  o_IMEM_REQ,
  output logic [AddrWidth-1:0]  o_IMEM_ADDR,
  input  logic                  i_IMEM_VALID,
  input  logic [InstrWidth-1:0] i_IMEM_RDATA,
  input  logic                  i_STALL_F,
  input  logic                  i_BRANCH_TAKEN,
  input  logic [AddrWidth-1:0]  i_BRANCH_TARGET,
  output logic                  o_VALID_F,
  output logic [InstrWidth-1:0] o_INSTR_F,
  output logic [AddrWidth-1:0]  o_PC_F,
  output logic [AddrWidth-1:0]  o_PCPLUS4_F
);

  localparam logic [AddrWidth-1:0] ALIGN_MASK  = ~AddrWidth'(INSTR_BYTES - 1);
  localparam logic [AddrWidth-1:0] PC_RESET    = ResetVector & ALIGN_MASK;

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] disc_addr_q, disc_addr_d;
  logic                 req_held_q, req_held_d;

  logic                 buf_valid;
  logic                 consume_c;
  logic                 load_c;
  logic                 req_c;
  logic [AddrWidth-1:0] addr_c;
  logic [AddrWidth-1:0] target_c;

  assign target_c    = i_BRANCH_TARGET & ALIGN_MASK;
  assign consume_c   = buf_valid & ~i_STALL_F;
  assign o_IMEM_REQ  = req_c;
  assign o_IMEM_ADDR = addr_c;
  assign o_VALID_F   = buf_valid;

  // State, PC and request-hold registers.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q     <= S_BOOT;
      pc_q        <= PC_RESET;
      disc_addr_q <= '0;
      req_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      req_held_q  <= req_held_d;
    end
  end

  // Next state, request issue and PC update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    req_held_d  = 1'b0;
    req_c       = 1'b0;
    addr_c      = pc_q;
    load_c      = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (i_BRANCH_TAKEN) pc_d = target_c;
      end

      S_REQ: begin
        // Once raised, the request stays up until the response, whatever the stall does.
        req_c = req_held_q | ~buf_valid | consume_c;
        if (i_BRANCH_TAKEN) begin
          pc_d = target_c;
          // Memory still owes a response for the current address: park on it.
          if (req_c && !i_IMEM_VALID) begin
            state_d     = S_DISCARD;
            disc_addr_d = pc_q;
          end
        end else if (req_c && i_IMEM_VALID) begin
          load_c = 1'b1;
          pc_d   = pc_q + AddrWidth'(INSTR_BYTES);
        end else if (req_c) begin
          req_held_d = 1'b1;
        end
      end

      S_DISCARD: begin
        req_c  = 1'b1;
        addr_c = disc_addr_q;
        if (i_BRANCH_TAKEN) pc_d = target_c;
        if (i_IMEM_VALID) state_d = S_REQ;
      end

      default: state_d = S_BOOT;
    endcase
  end

  arm_fetch_buffer #(
    .AddrWidth  (AddrWidth),
    .InstrWidth (InstrWidth)
  ) u_buffer (
    .i_CLK    (i_CLK),
    .i_NRESET (i_NRESET),
    .load     (load_c),
    .consume  (consume_c),
    .flush    (i_BRANCH_TAKEN),
    .instr_in (i_IMEM_RDATA),
    .pc_in    (pc_q),
    .valid    (buf_valid),
    .instr    (o_INSTR_F),
    .pc       (o_PC_F),
    .pcplus4  (o_PCPLUS4_F)
  );

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Directed bench for arm_fetch_stage with a variable-latency memory model.
module tb_arm_fetch_stage;

  logic        i_CLK;
  logic        i_NRESET;
  logic        o_IMEM_REQ;
  logic [31:0] o_IMEM_ADDR;
  logic        i_IMEM_VALID;
  logic [31:0] i_IMEM_RDATA;
  logic        i_STALL_F;
  logic        i_BRANCH_TAKEN;
  logic [31:0] i_BRANCH_TARGET;
  logic        o_VALID_F;
  logic [31:0] o_INSTR_F;
  logic [31:0] o_PC_F;
  logic [31:0] o_PCPLUS4_F;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned lat   = 0;
  int unsigned wait_cnt;

  arm_fetch_stage dut (
    .i_CLK           (i_CLK),
    .i_NRESET        (i_NRESET),
    .o_IMEM_REQ      (o_IMEM_REQ),
    .o_IMEM_ADDR     (o_IMEM_ADDR),
    .i_IMEM_VALID    (i_IMEM_VALID),
    .i_IMEM_RDATA    (i_IMEM_RDATA),
    .i_STALL_F       (i_STALL_F),
    .i_BRANCH_TAKEN  (i_BRANCH_TAKEN),
    .i_BRANCH_TARGET (i_BRANCH_TARGET),
    .o_VALID_F       (o_VALID_F),
    .o_INSTR_F       (o_INSTR_F),
    .o_PC_F          (o_PC_F),
    .o_PCPLUS4_F     (o_PCPLUS4_F)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Memory: answers after 'lat' wait cycles; data is a fixed function of address.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) wait_cnt <= 0;
    else if (o_IMEM_REQ && !i_IMEM_VALID) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign i_IMEM_VALID = o_IMEM_REQ && (wait_cnt >= lat);
  assign i_IMEM_RDATA = 32'hE3A0_0001 + o_IMEM_ADDR;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_buf(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(o_VALID_F), 32'd1);
    check_eq({tag, "_pc"}, o_PC_F, pc);
    check_eq({tag, "_pc4"}, o_PCPLUS4_F, pc + 32'd4);
    check_eq({tag, "_instr"}, o_INSTR_F, 32'hE3A0_0001 + pc);
  endtask

  task automatic check_req(input string tag, input logic exp_req, input logic [31:0] addr);
    check_eq({tag, "_req"}, 32'(o_IMEM_REQ), 32'(exp_req));
    if (exp_req) check_eq({tag, "_addr"}, o_IMEM_ADDR, addr);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, 32'(o_IMEM_REQ), 32'd0);
    check_eq({tag, "_valid"}, 32'(o_VALID_F), 32'd0);
    check_eq({tag, "_instr"}, o_INSTR_F, 32'd0);
    check_eq({tag, "_pc"}, o_PC_F, 32'd0);
    check_eq({tag, "_pc4"}, o_PCPLUS4_F, 32'd4);
  endtask

  initial begin
    i_NRESET = 1'b0;
    i_STALL_F = 1'b0;
    i_BRANCH_TAKEN = 1'b0;
    i_BRANCH_TARGET = '0;
    lat = 0;
    repeat (2) @(negedge i_CLK);
    #1 check_reset_vals("rst");

    // Zero-wait boot: idle cycle, request in cycle 2, data in cycle 3.
    @(negedge i_CLK); i_NRESET = 1'b1;
    #1 check_req("boot_c1", 1'b0, 32'h0);
    @(negedge i_CLK); #1 check_req("boot_c2", 1'b1, 32'h0);
    check_eq("boot_c2_valid", 32'(o_VALID_F), 32'd0);
    @(negedge i_CLK); #1 check_buf("zw_0", 32'h0);
    check_req("zw_0", 1'b1, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_CLK); #1 check_buf("zw_seq", 32'(4 * k));
    end

    // Three-cycle memory at 0x10.
    lat = 2;
    #1 check_req("lat_c0", 1'b1, 32'h10);
    @(negedge i_CLK); #1 check_req("lat_c1", 1'b1, 32'h10);
    check_eq("lat_c1_valid", 32'(o_VALID_F), 32'd0);
    @(negedge i_CLK); #1 check_req("lat_c2", 1'b1, 32'h10);
    check_eq("lat_c2_valid", 32'(o_VALID_F), 32'd0);
    @(negedge i_CLK); lat = 0;
    #1 check_buf("lat_out", 32'h10);
    check_req("lat_next", 1'b1, 32'h14);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_CLK); #1 check_buf("zw_b", 32'h14 + 32'(4 * k));
    end

    // Stall four cycles with 0x20 buffered.
    for (int k = 0; k < 4; k++) begin
      @(negedge i_CLK); i_STALL_F = 1'b1;
      #1 check_buf("stall_hold", 32'h20);
      check_req("stall_noreq", 1'b0, 32'h0);
    end
    @(negedge i_CLK); i_STALL_F = 1'b0;
    #1 check_req("stall_rel", 1'b1, 32'h24);
    check_buf("stall_rel", 32'h20);
    for (int k = 0; k < 7; k++) begin
      @(negedge i_CLK); #1 check_buf("zw_c", 32'h24 + 32'(4 * k));
    end

    // Redirect to 0x103 while 0x40 is outstanding.
    lat = 2;
    #1 check_req("rd_c0", 1'b1, 32'h40);
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b1; i_BRANCH_TARGET = 32'h103;
    #1 check_req("rd_c1", 1'b1, 32'h40);
    check_eq("rd_c1_valid", 32'(o_VALID_F), 32'd0);
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b0;
    #1 check_req("rd_disc", 1'b1, 32'h40);
    check_eq("rd_disc_valid", 32'(o_VALID_F), 32'd0);
    @(negedge i_CLK); lat = 0;
    #1 check_eq("rd_drop_valid", 32'(o_VALID_F), 32'd0);
    check_req("rd_target", 1'b1, 32'h100);

    // Redirect coinciding with stall on a full buffer.
    @(negedge i_CLK);
    i_STALL_F = 1'b1; i_BRANCH_TAKEN = 1'b1; i_BRANCH_TARGET = 32'h200;
    #1 check_buf("rd_out", 32'h100);
    check_req("sr_noreq", 1'b0, 32'h0);
    @(negedge i_CLK); i_STALL_F = 1'b0; i_BRANCH_TAKEN = 1'b0;
    #1 check_eq("sr_flush", 32'(o_VALID_F), 32'd0);
    check_req("sr_target", 1'b1, 32'h200);

    // Redirect to 0x7C, then reset mid-request to 0x80.
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b1; i_BRANCH_TARGET = 32'h7C;
    #1 check_buf("sr_out", 32'h200);
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b0;
    #1 check_eq("r7c_valid", 32'(o_VALID_F), 32'd0);
    check_req("r7c_req", 1'b1, 32'h7C);
    @(negedge i_CLK); lat = 5;
    #1 check_buf("mid_buf", 32'h7C);
    check_req("mid_req", 1'b1, 32'h80);
    #1 i_NRESET = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge i_CLK); lat = 0; i_NRESET = 1'b1;
    #1 check_req("rst2_c1", 1'b0, 32'h0);
    @(negedge i_CLK); #1 check_req("rst2_c2", 1'b1, 32'h0);

    // PC wrap at the top of the address space.
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b1; i_BRANCH_TARGET = 32'hFFFF_FFFC;
    #1 check_buf("rst2_out", 32'h0);
    @(negedge i_CLK); i_BRANCH_TAKEN = 1'b0;
    #1 check_eq("wrap_flush", 32'(o_VALID_F), 32'd0);
    check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    @(negedge i_CLK);
    #1 check_eq("wrap_pc", o_PC_F, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", o_PCPLUS4_F, 32'h0);
    check_req("wrap_next", 1'b1, 32'h0);
    @(negedge i_CLK); #1 check_buf("wrap_zero", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
